regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
Shares the single register-file write port among N_REQ write-back requesters: ALU result, memory load and vector-encryption unit.
- Each requester uses a valid/ready handshake.
- The block picks one winner per cycle, round-robin or fixed priority.
- The winning write is registered and drives the register file's regWrite/A3/WD3 one cycle later.
- It also exports a pending-write mask for hazard checks and a stall counter for performance monitoring.

Parameters:
N_REQ, 3, number of write requesters (2..8)
ADDR_W, 4, register address width (16 registers)
DATA_W, 32, write data width
RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-high
hold  input  1  freeze arbitration; no grants while high
req_valid  input  N_REQ  per-requester write request
req_ready  output  N_REQ  per-requester grant (one-hot or zero)
req_addr  input  N_REQ*ADDR_W  packed destination register, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  N_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
rf_we  output  1  to register file regWrite
rf_waddr  output  ADDR_W  to register file A3
rf_wdata  output  DATA_W  to register file WD3
pending_mask  output  2**ADDR_W  one-hot of rf_waddr while rf_we=1, else all zero
stall_cnt  output  16  saturating count of cycles with an unserved valid request

Behaviour:
- Reset (asynchronous, rst=1): rf_we=0, rf_waddr=0, rf_wdata=0, RR pointer=0, stall_cnt=0. pending_mask=0 follows rf_we. req_ready=0 while rst is high.
- req_ready is combinational from req_valid, hold and the pointer.
  - Exactly one bit is set when hold=0 and any valid is set.
  - Zero when hold=1 or no valid is set.
  - req_ready[i] is never set without req_valid[i].
- Transfer on requester i happens when req_valid[i] & req_ready[i]. At most one transfer per cycle.
- Protocol rule: once valid is raised, the requester holds it together with stable addr/data until the transfer. The bench checks this with an assertion; the RTL does not need to tolerate violations.
- Arbitration, RR_EN=1:
  - Search starts at index ptr and goes up, wrapping modulo N_REQ.
  - On a transfer by i, ptr <= (i+1) mod N_REQ; on wrap, N_REQ-1 goes to 0.
  - With no transfer, ptr holds.
  - Guarantee: a continuously valid requester is granted within N_REQ cycles of hold=0 cycles.
- Arbitration, RR_EN=0: lowest asserted index wins; ptr is unused and stays 0.
- Output stage: 1-cycle latency.
  - On a transfer: rf_we<=1, rf_waddr<=winner addr, rf_wdata<=winner data.
  - With no transfer: rf_we<=0; rf_waddr and rf_wdata hold their old values.
  - The register file commits on the following posedge, so data written is visible to a read 2 posedges after acceptance.
- Back-to-back transfers on consecutive cycles are legal and produce consecutive rf_we pulses.
- Same destination address from two requesters in one cycle: only the winner transfers; the loser is written on a later cycle (last writer wins in the register file).
- hold=1: no grants; the output stage drains, giving rf_we=0 in the next cycle. ptr and stall_cnt are frozen; hold cycles are not counted as stalls.
- stall_cnt increments by 1 on any cycle with hold=0 and at least one req_valid[i] & !req_ready[i]. It saturates at 16'hFFFF and does not wrap.
- Reset asserted mid-operation: any write in the output stage is dropped (rf_we forced to 0 immediately) and ptr returns to 0.

Decomposition:
- Package regfile_pkg holds:
  - constants RF_ADDR_W=4, RF_DATA_W=32, RF_NUM_REGS=16, REG_PU=13, REG_SP=14, REG_PC=15;
  - requester index enum: WB_ALU=0, WB_MEM=1, WB_VEC=2.
- Sub-module rr_arbiter: a generic N-way one-hot grant from a request vector, a pointer and a mode bit, plus the pointer update. It is purely combinational apart from the pointer flop, and is reusable for the memory port.

Test Plan:
- Reset: hold rst=1 with all valids high -> req_ready=0, rf_we=0, pending_mask=0, stall_cnt=0. Release -> grant goes to requester 0 first.
- Single request: valid[1] with addr=5, data=0xDEADBEEF -> req_ready[1] the same cycle. Next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, pending_mask=0x0020.
- RR fairness: all 3 valids held for 6 cycles with RR_EN=1 -> grant order 0,1,2,0,1,2. stall_cnt reaches 6, since at least one valid requester waits every cycle.
- Fixed priority: RR_EN=0 with valid[0] and valid[2] held for 3 cycles -> requester 0 is granted every cycle and requester 2 never. stall_cnt increments each cycle.
- Hold plus collision: valid[0] and valid[1] both with addr=14, hold=1 for 2 cycles -> no grants and stall_cnt unchanged. hold=0 -> writes to R14 from requesters 0 then 1 on consecutive cycles; the final R14 value is requester 1's data.
- Reset mid-write: assert rst in the cycle after a transfer -> rf_we drops immediately, and after release ptr=0 and no write appears.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and write-back requester indices.
package regfile_pkg;

    localparam int RF_ADDR_W   = 4;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 16;
    localparam int REG_PU      = 13;
    localparam int REG_SP      = 14;
    localparam int REG_PC      = 15;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_VEC = 2'd2
    } wb_req_e;

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way one-hot arbiter: round-robin from a rotating pointer, or fixed
// priority (lowest index) when rr_mode is low. Only the pointer is registered.
module rr_arbiter #(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rr_mode,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] win_idx;
    logic          found;
    int            idx;

    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = rr_mode ? ((int'(ptr_reg) + k) % N) : k;
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                win_idx    = PW'(idx);
                found      = 1'b1;
            end
        end
    end

    // In fixed-priority mode the pointer never leaves 0.
    always_comb begin
        ptr_next = ptr_reg;
        if (found && rr_mode) begin
            ptr_next = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among N_REQ write-back requesters and
// registers the winning write; also exports a pending mask and a stall counter.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W,
    parameter int RR_EN  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic [(2**ADDR_W)-1:0]    pending_mask,
    output logic [15:0]               stall_cnt
);

    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic [DATA_W-1:0] data_arr [N_REQ];
    logic [N_REQ-1:0]  grant;
    logic              arb_en;
    logic              transfer;
    logic              waiting;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    logic              rf_we_reg;
    logic [ADDR_W-1:0] rf_waddr_reg;
    logic [DATA_W-1:0] rf_wdata_reg;
    logic [15:0]       stall_cnt_reg;
    logic [15:0]       stall_cnt_next;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    // Grants are suppressed while held or in reset so no handshake completes.
    assign arb_en = !hold && !rst;

    rr_arbiter #(
        .N(N_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .rr_mode (RR_EN != 0),
        .en      (arb_en),
        .req     (req_valid),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign transfer  = |grant;
    assign waiting   = |(req_valid & ~grant);

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win_addr = addr_arr[i];
                win_data = data_arr[i];
            end
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (!hold && waiting && stall_cnt_reg != 16'hFFFF) begin
            stall_cnt_next = stall_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_reg     <= 1'b0;
            rf_waddr_reg  <= '0;
            rf_wdata_reg  <= '0;
            stall_cnt_reg <= '0;
        end else begin
            rf_we_reg     <= transfer;
            stall_cnt_reg <= stall_cnt_next;
            if (transfer) begin
                rf_waddr_reg <= win_addr;
                rf_wdata_reg <= win_data;
            end
        end
    end

    for (genvar gi = 0; gi < 2**ADDR_W; gi++) begin : g_pending
        assign pending_mask[gi] = rf_we_reg && (rf_waddr_reg == ADDR_W'(gi));
    end

    assign rf_we     = rf_we_reg;
    assign rf_waddr  = rf_waddr_reg;
    assign rf_wdata  = rf_wdata_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule
